// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with single-line refill FSM
module icache #(
    parameter int BLOCK_WIDTH = 1,
    parameter int CACHE_WIDTH = 8,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                          Sys_clk,
    input  logic                          Sys_rst_n,
    input  logic                          Sys_rdy,
    input  logic                          IFIC_en,
    input  logic [ADDR_WIDTH-1:0]         IFIC_addr,
    output logic                          ICIF_en,
    output logic [31:0]                   ICIF_inst,
    input  logic                          IC_clear,
    output logic                          ICMC_en,
    output logic [ADDR_WIDTH-1:0]         ICMC_addr,
    input  logic                          MCIC_en,
    input  logic [(32<<BLOCK_WIDTH)-1:0]  MCIC_block
);

    localparam int OFF    = BLOCK_WIDTH + 2;
    localparam int TAG_W  = ADDR_WIDTH - CACHE_WIDTH - OFF;
    localparam int LINES  = 1 << CACHE_WIDTH;
    localparam int LINE_W = 32 << BLOCK_WIDTH;

    typedef enum logic [0:0] {IDLE, MISS} state_t;

    state_t                   state;
    logic [LINES-1:0]         valid;
    logic [TAG_W-1:0]         tag_mem  [LINES];
    logic [LINE_W-1:0]        data_mem [LINES];
    logic [BLOCK_WIDTH-1:0]   pend_word;
    logic                     drop;

    logic [CACHE_WIDTH-1:0]   req_idx;
    logic [TAG_W-1:0]         req_tag;
    logic [BLOCK_WIDTH-1:0]   req_word;
    logic [CACHE_WIDTH-1:0]   fill_idx;
    logic [TAG_W-1:0]         fill_tag;
    logic [LINE_W-1:0]        rd_line;
    logic [31:0]              hit_word;
    logic [31:0]              fill_word;
    logic                     hit;
    logic                     fill;

    // Address decode for the incoming lookup and for the outstanding fill
    always_comb begin
        req_idx   = IFIC_addr[OFF +: CACHE_WIDTH];
        req_tag   = IFIC_addr[ADDR_WIDTH-1 -: TAG_W];
        req_word  = IFIC_addr[2 +: BLOCK_WIDTH];
        fill_idx  = ICMC_addr[OFF +: CACHE_WIDTH];
        fill_tag  = ICMC_addr[ADDR_WIDTH-1 -: TAG_W];
        rd_line   = data_mem[req_idx];
        hit_word  = rd_line[{req_word, 5'b00000} +: 32];
        fill_word = MCIC_block[{pend_word, 5'b00000} +: 32];
        hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
        fill      = Sys_rdy && (state == MISS) && MCIC_en;
    end

    // Tag/data storage: written only when a fill completes, never reset
    always_ff @(posedge Sys_clk) begin
        if (fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= MCIC_block;
        end
    end

    // Lookup/refill FSM with registered fetch and memory-request outputs
    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            state     <= IDLE;
            valid     <= '0;
            ICIF_en   <= 1'b0;
            ICIF_inst <= '0;
            ICMC_en   <= 1'b0;
            ICMC_addr <= '0;
            pend_word <= '0;
            drop      <= 1'b0;
        end else if (Sys_rdy) begin
            ICIF_en <= 1'b0;
            case (state)
                IDLE: begin
                    // A request still held high right after its response is not re-served
                    if (IFIC_en && !IC_clear && !ICIF_en) begin
                        if (hit) begin
                            ICIF_en   <= 1'b1;
                            ICIF_inst <= hit_word;
                        end else begin
                            ICMC_en   <= 1'b1;
                            ICMC_addr <= {IFIC_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                            pend_word <= req_word;
                            drop      <= 1'b0;
                            state     <= MISS;
                        end
                    end
                end
                MISS: begin
                    // The memory transfer cannot be aborted; a flush only suppresses the reply
                    if (MCIC_en) begin
                        valid[fill_idx] <= 1'b1;
                        ICMC_en         <= 1'b0;
                        if (!drop && !IC_clear) begin
                            ICIF_en   <= 1'b1;
                            ICIF_inst <= fill_word;
                        end
                        drop  <= 1'b0;
                        state <= IDLE;
                    end else if (IC_clear) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter BLOCK_WIDTH, default 1, log2 of instructions per line (2 x 32-bit instructions per line).
REQ-002 Parameter CACHE_WIDTH, default 8, log2 of line count (256 lines, direct-mapped).
REQ-003 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-004 Sys_clk  in  1  single clock; all state changes on rising edge.
REQ-005 Sys_rst_n  in  1  asynchronous, active-low reset.
REQ-006 Sys_rdy  in  1  global enable; when 0, all state and outputs hold.
REQ-007 IFIC_en  in  1  fetch request from fetch unit, held until ICIF_en.
REQ-008 IFIC_addr  in  ADDR_WIDTH  fetch PC, word-aligned.
REQ-009 ICIF_en  out  1  one-cycle pulse: ICIF_inst valid.
REQ-010 ICIF_inst  out  32  fetched instruction.
REQ-011 IC_clear  in  1  pipeline flush; discards any outstanding fetch.
REQ-012 ICMC_en  out  1  line-fill request to memory controller.
REQ-013 ICMC_addr  out  ADDR_WIDTH  line-aligned fill address (low 3 bits zero).
REQ-014 MCIC_en  in  1  one-cycle pulse from memory controller: MCIC_block valid.
REQ-015 MCIC_block  in  64  filled line; byte at ICMC_addr+k in bits [8k+7:8k].

Function
REQ-016 Address split SHALL be: [1:0] ignored, [2] word select, [10:3] index, [31:11] tag.
REQ-017 Storage SHALL be 256 entries of {valid, 21-bit tag, 64-bit data}; word 0 = data[31:0], word 1 = data[63:32].
REQ-018 FSM states SHALL be IDLE and MISS.
REQ-019 IDLE, IFIC_en=1, IC_clear=0, valid&&tag match: ICIF_en=1 and ICIF_inst=selected word at next edge (1-cycle hit latency); stay IDLE.
REQ-020 IDLE, IFIC_en=1, miss: at next edge ICMC_en=1, ICMC_addr={IFIC_addr[31:3],3'b000}, latch pending PC, go MISS.
REQ-021 ICIF_en SHALL be a single-cycle pulse; cleared on every edge it is not re-asserted.
REQ-022 After an ICIF_en pulse, the same request SHALL NOT be served again that cycle: a new lookup starts only when IFIC_en is sampled high with ICIF_en=0.
REQ-023 MISS: ICMC_en and ICMC_addr SHALL hold stable until MCIC_en sampled 1.
REQ-024 MISS, MCIC_en=1: write line (valid=1, tag, data) at latched index; deassert ICMC_en at that edge (registered); return word selected by latched PC[2] via ICIF_en pulse at same edge; go IDLE.
REQ-025 ICMC_en SHALL be low in the cycle after an MCIC_en pulse, so the memory controller does not re-serve the request.
REQ-026 IC_clear in IDLE: no lookup, no ICIF_en, no fill; stay IDLE.
REQ-027 IC_clear in MISS: fill SHALL continue (memory transfer not abortable); line written on MCIC_en; ICIF_en suppressed; set internal drop flag until fill completes.
REQ-028 IC_clear and MCIC_en same edge: line written, ICIF_en=0, go IDLE.
REQ-029 New request while MISS (PC changed after flush): ignored until return to IDLE.
REQ-030 MCIC_en while IDLE: ignored, no array write.
REQ-031 Sys_rdy=0: FSM, array, and all outputs hold; an MCIC_en pulse during Sys_rdy=0 is not expected (memory controller is frozen too).

Reset
REQ-032 Sys_rst_n=0 SHALL immediately clear all valid bits, state to IDLE, ICIF_en=0, ICIF_inst=0, ICMC_en=0, ICMC_addr=0, drop flag=0.
REQ-033 Reset mid-MISS SHALL abandon the fill; a later MCIC_en pulse is ignored per REQ-030.
REQ-034 Data and tag arrays need not be reset; only valid bits.

Verification
REQ-035 Cold miss: reset, IFIC_addr=0x0000_1004 -> ICMC_en=1, ICMC_addr=0x0000_1000; MCIC_block=0x22222222_11111111 -> ICIF_inst=0x22222222, ICMC_en=0 next cycle.
REQ-036 Hit: then fetch 0x0000_1000 -> ICIF_en one cycle after request, ICIF_inst=0x11111111, ICMC_en stays 0.
REQ-037 Conflict: fetch 0x0000_1800 (same index 0, new tag) -> miss, refill; re-fetch 0x0000_1000 -> miss again.
REQ-038 Flush mid-miss: miss on 0x2000, IC_clear pulse, MCIC_en 3 cycles later -> no ICIF_en; fetch 0x2000 -> hit.
REQ-039 Async reset mid-miss: Sys_rst_n low between edges -> ICMC_en=0 immediately; fetch 0x0000_1000 after release -> miss.
REQ-040 Sys_rdy stall: Sys_rdy=0 for 4 cycles during hit lookup -> ICIF_en delayed, no duplicate pulse, value unchanged.
